// File: rtl/demux_32bit_reg_if.sv
// Handshake and status bundle for the registered 1-to-NUM_OUT demultiplexer.
// The producer and the lane consumers sit on the master side; the demux is the slave.
interface demux_32bit_reg_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
);

  // Producer side
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic [SEL_W-1:0]         in_sel;

  // Per-lane consumer side
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;

  // Status
  logic                     sel_err;
  logic [15:0]              xfer_count;

  modport master (
    output in_valid,
    output in_data,
    output in_sel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  sel_err,
    input  xfer_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output sel_err,
    output xfer_count
  );

endinterface

// File: rtl/demux_32bit_reg.sv
// Registered 1-to-NUM_OUT demultiplexer. One word per handshake is steered by
// in_sel into a per-lane holding slot; each slot is drained independently by its
// own valid/ready consumer. A lane that drains and fills on the same edge keeps
// its valid flag set, so every lane sustains one word per cycle.
module demux_32bit_reg #(
  parameter int WIDTH   = 32,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input logic               clk,
  input logic               reset,
  demux_32bit_reg_if.slave  bus
);

  // NUM_OUT fits in SEL_W+1 bits because 2**SEL_W >= NUM_OUT.
  localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W + 1)'(NUM_OUT);

  logic                           in_range;
  logic [NUM_OUT-1:0]             lane_hit;
  logic [NUM_OUT-1:0]             lane_free;
  logic [NUM_OUT-1:0]             drain;
  logic [NUM_OUT-1:0]             load;
  logic                           accept;

  logic [NUM_OUT-1:0]             valid_q;
  logic [NUM_OUT-1:0]             valid_d;
  logic [NUM_OUT-1:0][WIDTH-1:0]  data_q;
  logic                           sel_err_q;
  logic [15:0]                    count_q;

  // Decode the addressed lane and work out which slots can take a word this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    in_range  = ({1'b0, bus.in_sel} < NUM_OUT_W);
    lane_hit  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      lane_hit[i] = in_range && (bus.in_sel == SEL_W'(i));
    end
    // A slot is free if empty, or if its consumer empties it on this same edge.
    lane_free = ~valid_q | bus.out_ready;
    drain     = valid_q & bus.out_ready;
  end

  // Out-of-range words are always accepted (and dropped); in-range words only
  // wait on their own lane, never on other full lanes.
  assign bus.in_ready = ~in_range | (|(lane_hit & lane_free));
  assign accept       = bus.in_valid & bus.in_ready;
  assign load         = {NUM_OUT{accept}} & lane_hit;

  // Next slot occupancy: a load wins over a drain, otherwise a drain empties the slot.
  always_comb begin
    valid_d = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (load[i]) begin
        valid_d[i] = 1'b1;
      end else if (drain[i]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
  end

  // Slot valid flags.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Slot data registers; only written on a load, so an undrained word is held
  // and an empty lane keeps showing its last word.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the slot data is reset too, because downstream sees out_data=0
    // straight out of reset; a plain storage array would not need this.
    if (reset) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (load[i]) begin
          data_q[i] <= bus.in_data;
        end
      end
    end
  end

  // Sticky flag for words addressed to a lane that does not exist.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else if (accept && !in_range) begin
      sel_err_q <= 1'b1;
    end
  end

  // Count of words delivered into a lane; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (accept && in_range) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.sel_err    = sel_err_q;
  assign bus.xfer_count = count_q;

endmodule
